sift_pixel_streamer: RTL

Raster pixel source for the SIFT dominant-orientation datapath. It reads a stored image from synchronous frame memory and drives an unbroken one-pixel-per-clock stream into the 3x3 window builder; that builder's line buffers shift every clock and have no enable. After the last pixel it shifts in zero-valued flush pixels so the final image rows drain through the line-buffer taps. It also outputs per-pixel valid, row/column coordinates and frame markers for downstream consumers.

---
 rtl/sift_pixel_streamer.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/sift_pixel_streamer.sv
// Raster pixel source: reads a stored frame from synchronous memory and drives a gapless
// one-pixel-per-clock stream, followed by zero flush pixels that drain the window line buffers.
//   state | meaning
//   IDLE  | waiting for istart, no reads
//   READ  | issuing one memory read per clock
//   DRAIN | last read in flight
//   FLUSH | emitting FLUSH_LEN zero pixels
module sift_pixel_streamer #(
    parameter int IMG_W     = 640,
    parameter int IMG_H     = 480,
    parameter int DATA_W    = 9,
    parameter int ADDR_W    = 19,
    parameter int FLUSH_LEN = 2*IMG_W+2
) (
    input  logic                     iclk,
    input  logic                     irst_n,
    input  logic                     istart,
    input  logic                     iabort,
    output logic [ADDR_W-1:0]        ordaddr,
    output logic                     ordreq,
    input  logic [DATA_W-1:0]        irddata,
    output logic [DATA_W-1:0]        odata,
    output logic                     ovalid,
    output logic [$clog2(IMG_W)-1:0] ocol,
    output logic [$clog2(IMG_H)-1:0] orow,
    output logic                     osof,
    output logic                     oeol,
    output logic                     oeof,
    output logic                     oflush,
    output logic                     obusy,
    output logic                     odone
);

    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);
    localparam int FW = $clog2(FLUSH_LEN+1);
    localparam logic [ADDR_W-1:0] ADDR_LAST  = ADDR_W'(IMG_W*IMG_H-1);
    localparam logic [CW-1:0]     COL_LAST   = CW'(IMG_W-1);
    localparam logic [RW-1:0]     ROW_LAST   = RW'(IMG_H-1);
    localparam logic [FW-1:0]     FLUSH_LOAD = FW'(FLUSH_LEN-1);

    typedef enum logic [1:0] {IDLE, READ, DRAIN, FLUSH} state_t;

    state_t          state;
    state_t          state_nxt;
    logic            rd_vld;
    logic [FW-1:0]   flush_cnt;
    logic [CW-1:0]   pix_col;
    logic [RW-1:0]   pix_row;
    logic            flush_last;

    assign flush_last = (flush_cnt == '0);
    assign obusy      = (state != IDLE);

    always_ff @(posedge iclk or negedge irst_n) begin
        if (!irst_n) begin
            state <= IDLE;
        end else if (iabort) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (istart) state_nxt = READ;
            READ:    if (ordaddr == ADDR_LAST) state_nxt = DRAIN;
            DRAIN:   state_nxt = FLUSH;
            FLUSH:   if (flush_last) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge iclk or negedge irst_n) begin
        if (!irst_n) begin
            ordaddr   <= '0;
            ordreq    <= 1'b0;
            rd_vld    <= 1'b0;
            flush_cnt <= '0;
            pix_col   <= '0;
            pix_row   <= '0;
            odata     <= '0;
            ovalid    <= 1'b0;
            ocol      <= '0;
            orow      <= '0;
            osof      <= 1'b0;
            oeol      <= 1'b0;
            oeof      <= 1'b0;
            oflush    <= 1'b0;
            odone     <= 1'b0;
        end else if (iabort) begin
            ordaddr   <= '0;
            ordreq    <= 1'b0;
            rd_vld    <= 1'b0;
            flush_cnt <= '0;
            pix_col   <= '0;
            pix_row   <= '0;
            odata     <= '0;
            ovalid    <= 1'b0;
            ocol      <= '0;
            orow      <= '0;
            osof      <= 1'b0;
            oeol      <= 1'b0;
            oeof      <= 1'b0;
            oflush    <= 1'b0;
            odone     <= 1'b0;
        end else begin
            ordreq  <= (state_nxt == READ);
            ordaddr <= (state == READ && state_nxt == READ) ? ordaddr + ADDR_W'(1) : '0;
            // rd_vld marks the cycle irddata holds the word addressed one edge earlier
            rd_vld  <= ordreq;
            odata   <= rd_vld ? irddata : '0;
            ovalid  <= rd_vld;
            ocol    <= rd_vld ? pix_col : '0;
            orow    <= rd_vld ? pix_row : '0;
            osof    <= rd_vld && pix_col == '0 && pix_row == '0;
            oeol    <= rd_vld && pix_col == COL_LAST;
            oeof    <= rd_vld && pix_col == COL_LAST && pix_row == ROW_LAST;
            oflush  <= (state == FLUSH);
            odone   <= (state == FLUSH) && flush_last;

            if (rd_vld) begin
                if (pix_col == COL_LAST) begin
                    pix_col <= '0;
                    pix_row <= (pix_row == ROW_LAST) ? '0 : pix_row + RW'(1);
                end else begin
                    pix_col <= pix_col + CW'(1);
                end
            end

            if (state == DRAIN) begin
                flush_cnt <= FLUSH_LOAD;
            end else if (state == FLUSH && !flush_last) begin
                flush_cnt <= flush_cnt - FW'(1);
            end
        end
    end

endmodule
